// File: rtl/sd_write_responder.sv
// Purpose : receives pixel writes (SD_write/SD_wdata/SD_address), queues them in a
//           DEPTH-entry FIFO and replays each one as a single-beat Avalon-MM master write.
// Latency : a write pushed into an empty, idle FIFO on edge t shows avm_write=1 after edge t+1.
//           Peak rate is 1 beat per cycle.
// Backpr. : SD_ready is registered (fifo_count < DEPTH). A write offered while SD_ready=0 is
//           dropped and sets the sticky overflow flag. avm_waitrequest stalls the current beat.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   SD_write/wdata/address   upstream write request, data and byte address
//   SD_ready                 FIFO can accept a write this cycle
//   frame_ready              pulse: last pixel of the frame has been issued upstream
//   frame_done               pulse: every write of that frame has been accepted by memory
//   avm_address/writedata    Avalon write address and data (held stable during waitrequest)
//   avm_write                Avalon write strobe
//   avm_waitrequest          Avalon slave stall
//   fifo_count               current FIFO occupancy
//   overflow                 sticky: a write was offered while SD_ready=0
module sd_write_responder #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     SD_write,
  input  logic [DATA_W-1:0]        SD_wdata,
  input  logic [ADDR_W-1:0]        SD_address,
  output logic                     SD_ready,
  input  logic                     frame_ready,
  output logic                     frame_done,
  output logic [ADDR_W-1:0]        avm_address,
  output logic [DATA_W-1:0]        avm_writedata,
  output logic                     avm_write,
  input  logic                     avm_waitrequest,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [ENT_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, head_idx;
  logic [CNT_W-1:0]   count_nxt;
  logic               push, pop, load, bypass;
  logic               flush_pending, done_cond;

  // Entry storage carries no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {SD_address, SD_wdata};
    end
  end

  always_comb begin
    push      = SD_write && SD_ready;
    pop       = (state == WRITE) && !avm_waitrequest;
    state_nxt = state;
    load      = 1'b0;
    bypass    = 1'b0;
    count_nxt = fifo_count;

    unique case ({push, pop})
      2'b10:   count_nxt = fifo_count + CNT_W'(1);
      2'b01:   count_nxt = fifo_count - CNT_W'(1);
      default: count_nxt = fifo_count;
    endcase

    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          load      = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (!avm_waitrequest) begin
          if (fifo_count > CNT_W'(1)) begin
            // Next entry already resident behind the head being retired.
            load = 1'b1;
          end else if (push) begin
            // FIFO drains to empty this edge, but a write arrives at the same
            // time: forward it straight onto the bus to keep beats back-to-back.
            load   = 1'b1;
            bypass = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // The head only advances once its beat completes, so after a pop the next
    // entry sits one slot past rd_ptr.
    head_idx  = pop ? (rd_ptr + PTR_W'(1)) : rd_ptr;

    // Holding off while a push lands keeps a write accepted alongside
    // frame_ready inside the current frame.
    done_cond = flush_pending && (fifo_count == '0) && (state == IDLE) && !push;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      SD_ready      <= 1'b1;
      overflow      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
      flush_pending <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state      <= state_nxt;
      fifo_count <= count_nxt;
      SD_ready   <= (count_nxt != CNT_W'(DEPTH));

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      if (SD_write && !SD_ready) overflow <= 1'b1;

      avm_write <= (state_nxt == WRITE);
      if (load) begin
        if (bypass) begin
          avm_address   <= SD_address;
          avm_writedata <= SD_wdata;
        end else begin
          {avm_address, avm_writedata} <= mem[head_idx];
        end
      end

      frame_done <= done_cond;
      if (done_cond) begin
        flush_pending <= 1'b0;
      end else if (frame_ready) begin
        flush_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sd_write_responder.sv
module tb_sd_write_responder;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        SD_write;
  logic [15:0] SD_wdata;
  logic [31:0] SD_address;
  logic        SD_ready;
  logic        frame_ready;
  logic        frame_done;
  logic [31:0] avm_address;
  logic [15:0] avm_writedata;
  logic        avm_write;
  logic        avm_waitrequest;
  logic [3:0]  fifo_count;
  logic        overflow;

  typedef struct packed {
    logic [31:0] a;
    logic [15:0] d;
  } beat_t;

  beat_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    beats_seen  = 0;

  always #5 clk = ~clk;

  sd_write_responder #(.DEPTH(DEPTH), .DATA_W(16), .ADDR_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .SD_write        (SD_write),
    .SD_wdata        (SD_wdata),
    .SD_address      (SD_address),
    .SD_ready        (SD_ready),
    .frame_ready     (frame_ready),
    .frame_done      (frame_done),
    .avm_address     (avm_address),
    .avm_writedata   (avm_writedata),
    .avm_write       (avm_write),
    .avm_waitrequest (avm_waitrequest),
    .fifo_count      (fifo_count),
    .overflow        (overflow)
  );

  // One clock step. At the falling edge, any beat that will be accepted on the
  // coming rising edge is checked against the scoreboard; inputs are then left
  // to change 1 ns after the rising edge.
  task automatic cycle();
    beat_t e;
    @(negedge clk);
    if (!rst && avm_write && !avm_waitrequest) begin
      vectors++;
      beats_seen++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL beat_unexpected: got addr=%h data=%h, required no beat", avm_address, avm_writedata);
      end else begin
        e = exp_q.pop_front();
        if ({avm_address, avm_writedata} !== e) begin
          miscompares++;
          $display("FAIL beat_order: got addr=%h data=%h, required addr=%h data=%h",
                   avm_address, avm_writedata, e.a, e.d);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [15:0] d, input logic accept);
    SD_write   = 1'b1;
    SD_address = a;
    SD_wdata   = d;
    vectors++;
    if (SD_ready !== accept) begin
      miscompares++;
      $display("FAIL sd_ready_at_push: addr=%h got SD_ready=%b, required %b", a, SD_ready, accept);
    end
    if (accept) exp_q.push_back({a, d});
    cycle();
    SD_write = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || avm_write) && n < budget) begin
      cycle();
      n++;
    end
    vectors++;
    if (exp_q.size() != 0 || avm_write !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d beats outstanding avm_write=%b, required 0 and 0", name, exp_q.size(), avm_write);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (SD_ready !== 1'b1) begin miscompares++; $display("FAIL reset_sd_ready: got %b, required 1", SD_ready); end
    vectors++;
    if (avm_write !== 1'b0 || frame_done !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got avm_write=%b frame_done=%b overflow=%b, required 0 0 0", avm_write, frame_done, overflow);
    end
    vectors++;
    if (avm_address !== 32'h0 || avm_writedata !== 16'h0 || fifo_count !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_regs: got addr=%h data=%h count=%0d, required 0 0 0", avm_address, avm_writedata, fifo_count);
    end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_single();
    int b0 = beats_seen;
    push(32'h0000_0100, 16'hABCD, 1'b1);
    vectors++;
    if (fifo_count !== 4'd1 || avm_write !== 1'b0) begin
      miscompares++;
      $display("FAIL single_after_push: got count=%0d avm_write=%b, required 1 0", fifo_count, avm_write);
    end
    cycle();
    vectors++;
    if (avm_write !== 1'b1 || avm_address !== 32'h0000_0100 || avm_writedata !== 16'hABCD) begin
      miscompares++;
      $display("FAIL single_present: got write=%b addr=%h data=%h, required 1 00000100 abcd", avm_write, avm_address, avm_writedata);
    end
    cycle();
    vectors++;
    if (avm_write !== 1'b0 || fifo_count !== 4'd0 || beats_seen - b0 !== 1) begin
      miscompares++;
      $display("FAIL single_done: got write=%b count=%0d beats=%0d, required 0 0 1", avm_write, fifo_count, beats_seen - b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] wv = '0;
    for (int i = 0; i < 4; i++) begin
      push(32'(2 * i), 16'h1000 + 16'(i), 1'b1);
      wv = {wv[4:0], avm_write};
    end
    for (int i = 0; i < 2; i++) begin
      cycle();
      wv = {wv[4:0], avm_write};
    end
    vectors++;
    if (wv !== 6'b011110) begin
      miscompares++;
      $display("FAIL back_to_back_strobe: got avm_write history %b, required 011110", wv);
    end
    wait_drain(10, "back_to_back");
  endtask

  task automatic test_waitrequest();
    avm_waitrequest = 1'b1;
    push(32'h0000_0010, 16'h1111, 1'b1);
    cycle();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (avm_write !== 1'b1 || avm_address !== 32'h10 || avm_writedata !== 16'h1111 || fifo_count !== 4'd1) begin
        miscompares++;
        $display("FAIL stall_hold_%0d: got write=%b addr=%h data=%h count=%0d, required 1 00000010 1111 1",
                 i, avm_write, avm_address, avm_writedata, fifo_count);
      end
      if (i < 4) cycle();
    end
    avm_waitrequest = 1'b0;
    cycle();
    vectors++;
    if (fifo_count !== 4'd0 || avm_write !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_release: got count=%0d write=%b, required 0 0", fifo_count, avm_write);
    end
  endtask

  task automatic test_overflow();
    int b0 = beats_seen;
    avm_waitrequest = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(32'h0000_1000 + 32'(4 * i), 16'h2000 + 16'(i), 1'b1);
    push(32'h0000_1FFF, 16'hDEAD, 1'b0);
    vectors++;
    if (overflow !== 1'b1 || fifo_count !== 4'(DEPTH) || SD_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_full: got overflow=%b count=%0d SD_ready=%b, required 1 %0d 0", overflow, fifo_count, SD_ready, DEPTH);
    end
    avm_waitrequest = 1'b0;
    wait_drain(20, "overflow");
    vectors++;
    if (beats_seen - b0 !== DEPTH || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_beats: got %0d beats overflow=%b, required %0d 1", beats_seen - b0, overflow, DEPTH);
    end
  endtask

  task automatic test_frame();
    int pulses = 0;
    avm_waitrequest = 1'b0;
    push(32'h0000_0300, 16'h0001, 1'b1);
    push(32'h0000_0302, 16'h0002, 1'b1);
    frame_ready = 1'b1;
    push(32'h0000_0304, 16'h0003, 1'b1);
    frame_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      avm_waitrequest = (i < 2);
      frame_ready     = (i == 0);  // second request while still pending
      cycle();
      frame_ready = 1'b0;
      if (frame_done === 1'b1) begin
        pulses++;
        vectors++;
        if (exp_q.size() != 0 || fifo_count !== 4'd0) begin
          miscompares++;
          $display("FAIL frame_done_early: pulse with %0d beats outstanding count=%0d, required 0 0", exp_q.size(), fifo_count);
        end
      end
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("FAIL frame_done_pulses: got %0d, required 1", pulses);
    end
    // Frame request while already empty and idle.
    frame_ready = 1'b1;
    cycle();
    frame_ready = 1'b0;
    vectors++;
    if (frame_done !== 1'b0) begin miscompares++; $display("FAIL frame_idle_t0: got %b, required 0", frame_done); end
    cycle();
    vectors++;
    if (frame_done !== 1'b1) begin miscompares++; $display("FAIL frame_idle_t1: got %b, required 1", frame_done); end
    cycle();
    vectors++;
    if (frame_done !== 1'b0) begin miscompares++; $display("FAIL frame_idle_t2: got %b, required 0", frame_done); end
  endtask

  task automatic test_reset_mid_write();
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) push(32'h0000_4000 + 32'(2 * i), 16'h4000 + 16'(i), 1'b1);
    vectors++;
    if (avm_write !== 1'b1 || fifo_count !== 4'd5) begin
      miscompares++;
      $display("FAIL rst_mid_setup: got write=%b count=%0d, required 1 5", avm_write, fifo_count);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (avm_write !== 1'b0 || fifo_count !== 4'd0 || SD_ready !== 1'b1 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_async: got write=%b count=%0d SD_ready=%b overflow=%b, required 0 0 1 0",
               avm_write, fifo_count, SD_ready, overflow);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst             = 1'b0;
    avm_waitrequest = 1'b0;
    cycle();
    push(32'h0000_0200, 16'h5A5A, 1'b1);
    cycle();
    vectors++;
    if (avm_write !== 1'b1 || avm_address !== 32'h200 || avm_writedata !== 16'h5A5A) begin
      miscompares++;
      $display("FAIL rst_mid_recover: got write=%b addr=%h data=%h, required 1 00000200 5a5a", avm_write, avm_address, avm_writedata);
    end
    wait_drain(10, "rst_mid");
  endtask

  initial begin
    rst             = 1'b1;
    SD_write        = 1'b0;
    SD_wdata        = '0;
    SD_address      = '0;
    frame_ready     = 1'b0;
    avm_waitrequest = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_waitrequest();
    test_overflow();
    test_frame();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sd_write_responder.md
Name: sd_write_responder

Overview:
- Receiving end of the pixel-output-to-SD_RAM write interface (SD_write / SD_wdata / SD_address).
- Buffers incoming 16-bit pixel writes in a FIFO and replays them as single-beat Avalon-MM master writes to the SDRAM controller, honouring waitrequest.
- Signals upstream backpressure through SD_ready.
- Reports end-of-frame completion once every write of a frame has been accepted by memory.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2
DATA_W, 16, pixel data width
ADDR_W, 32, byte address width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
SD_write  in  1  write request from output controller
SD_wdata  in  DATA_W  pixel data
SD_address  in  ADDR_W  destination address
SD_ready  out  1  FIFO can accept a write this cycle
frame_ready  in  1  single-cycle pulse: last pixel of the frame has been issued upstream
frame_done  out  1  single-cycle pulse: all writes of the frame have completed to memory
avm_address  out  ADDR_W  Avalon write address
avm_writedata  out  DATA_W  Avalon write data
avm_write  out  1  Avalon write strobe
avm_waitrequest  in  1  Avalon slave stall
fifo_count  out  log2(DEPTH)+1  current occupancy
overflow  out  1  sticky: a write was presented while SD_ready=0

Behaviour:
- Clock and reset are fixed: one clock, clk; rst is asynchronous and active-high.
- While rst is high, all outputs are 0 except SD_ready, which is 1. The FIFO is emptied, the FSM goes to IDLE, and flush_pending is cleared. Any transfer in flight when reset asserts is abandoned, and avm_write drops immediately.
- SD_ready is a registered value: 1 when fifo_count < DEPTH.
- Push condition: SD_write && SD_ready. The {SD_address, SD_wdata} pair is written at the write pointer on that edge.
- SD_write && !SD_ready: the write is dropped, overflow is set, and overflow stays set until reset.
- No push occurs when the FIFO is full, even if a pop happens in the same cycle. Full is evaluated on the registered count.
- Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo DEPTH.
- FSM, state IDLE:
  - If fifo_count > 0, load the head entry into the avm_address / avm_writedata registers, set avm_write=1, and go to WRITE.
  - Otherwise hold avm_write=0.
- FSM, state WRITE:
  - While avm_waitrequest=1, avm_address, avm_writedata and avm_write=1 are held stable.
  - On a cycle with avm_waitrequest=0 the beat completes and the head is popped on that edge.
  - If another entry is present after the pop (count-1 > 0, or a push in the same cycle), the next head loads on the same edge and avm_write stays 1. This gives back-to-back beats.
  - Otherwise avm_write goes to 0 and the FSM returns to IDLE.
- Latency: a write pushed into an empty FIFO with the FSM in IDLE on edge t is presented on the Avalon bus (avm_write=1) after edge t+1. Peak throughput is 1 beat per cycle.
- A frame_ready pulse sets flush_pending. A further frame_ready while already pending is merged and does not produce a second frame_done.
- frame_done pulses for exactly one cycle on the first edge where all of these hold: flush_pending=1, fifo_count=0, FSM in IDLE, no push that cycle. flush_pending clears on the same edge.
- frame_ready arriving while the FIFO is already empty and idle: frame_done is asserted on the following cycle.
- SD_write accepted in the same cycle as frame_ready counts as part of the current frame, so frame_done waits for it.

Test Plan:
1. Reset, then a single write (addr 0x0000_0100, data 0xABCD) -> avm_write=1 two cycles later with those values; avm_waitrequest=0 -> one beat; fifo_count returns to 0; FSM goes to IDLE.
2. Four consecutive writes (addr 0x0, 0x2, 0x4, 0x6) with avm_waitrequest=0 -> four back-to-back beats in order; avm_write is continuously 1 for 4 cycles.
3. avm_waitrequest held 1 for 5 cycles during the beat at addr 0x10 -> avm_address/avm_writedata stay stable; no pop until waitrequest drops.
4. With avm_waitrequest=1, push DEPTH+1 writes -> SD_ready=0 after 8 entries; the ninth write is dropped and overflow=1 (sticky). Release waitrequest -> exactly 8 beats, in order.
5. Push 3 writes, pulse frame_ready on the third, stall for 2 cycles -> frame_done is a single pulse only after the third beat completes; a second frame_ready while pending yields no extra pulse.
6. Assert rst mid-WRITE with 5 entries queued -> avm_write=0 immediately, fifo_count=0, SD_ready=1; after release a new write is serviced normally.
